// File: rtl/im_program_loader_if.sv
// Byte-source and instruction-memory write bus for the program loader.
// master = byte source / memory side, slave = loader.
interface im_program_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, write_addr, write_data, write
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, write_addr, write_data, write
  );
endinterface

// File: rtl/im_program_loader.sv
// Framed byte-stream boot loader: SYNC, BASE, LEN, payload words, CSUM.
// Writes big-endian words into instruction memory and publishes the base on a good checksum.
module im_program_loader #(
  parameter int         DATA_WIDTH     = 32,
  parameter int         ADDR_WIDTH     = 14,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic                  clock,
  input  logic                  reset,
  im_program_loader_if.slave    rx_wr,
  output logic [DATA_WIDTH-1:0] IM_offset,
  output logic                  FLAG_IMoffset,
  output logic                  hold_cpu,
  output logic                  done,
  output logic                  error
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_BASE = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_CSUM = 3'd5;

  logic [2:0]  state;
  logic [31:0] base_q;
  logic [31:0] len_q;
  logic [23:0] word_q;
  logic [31:0] word_idx;
  logic [31:0] tcount;
  logic [7:0]  csum;
  logic [1:0]  byte_cnt;

  logic        accept;
  logic [31:0] len_next;
  logic [31:0] word_next;
  logic [34:0] span;
  logic        too_big;
  logic        counting;
  logic        timed_out;

  assign rx_wr.rx_ready = (state != S_WR);
  assign hold_cpu       = (state != S_IDLE);
  assign accept         = rx_wr.rx_valid & rx_wr.rx_ready;
  assign len_next       = {len_q[23:0], rx_wr.rx_data};
  assign word_next      = {word_q, rx_wr.rx_data};
  // 35-bit sum so a huge base/len cannot wrap past the range check
  assign span           = 35'(base_q) + 35'(len_next);
  assign too_big        = span > (35'd1 << ADDR_WIDTH);
  assign counting       = (state == S_BASE) || (state == S_LEN) ||
                          (state == S_DATA) || (state == S_CSUM);
  assign timed_out      = counting && !accept && (tcount == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= S_IDLE;
      base_q           <= '0;
      len_q            <= '0;
      word_q           <= '0;
      word_idx         <= '0;
      tcount           <= '0;
      csum             <= '0;
      byte_cnt         <= '0;
      rx_wr.write      <= 1'b0;
      rx_wr.write_addr <= '0;
      rx_wr.write_data <= '0;
      IM_offset        <= '0;
      FLAG_IMoffset    <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
    end else begin
      rx_wr.write   <= 1'b0;
      FLAG_IMoffset <= 1'b0;

      if (accept || !counting) tcount <= '0;
      else                     tcount <= tcount + 32'd1;

      if (timed_out) begin
        state <= S_IDLE;
        error <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (accept && rx_wr.rx_data == SYNC_BYTE) begin
            state    <= S_BASE;
            done     <= 1'b0;
            error    <= 1'b0;
            csum     <= '0;
            byte_cnt <= '0;
            word_idx <= '0;
          end
          S_BASE: if (accept) begin
            base_q   <= {base_q[23:0], rx_wr.rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) state <= S_LEN;
          end
          S_LEN: if (accept) begin
            len_q    <= len_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (too_big) begin
                state <= S_IDLE;
                error <= 1'b1;
              end else if (len_next == '0) begin
                state <= S_CSUM;
              end else begin
                state <= S_DATA;
              end
            end
          end
          S_DATA: if (accept) begin
            word_q   <= word_next[23:0];
            csum     <= csum + rx_wr.rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state            <= S_WR;
              rx_wr.write      <= 1'b1;
              rx_wr.write_addr <= base_q + word_idx;
              rx_wr.write_data <= word_next;
            end
          end
          S_WR: begin
            word_idx <= word_idx + 32'd1;
            state    <= (word_idx + 32'd1 == len_q) ? S_CSUM : S_DATA;
          end
          S_CSUM: if (accept) begin
            state <= S_IDLE;
            if (rx_wr.rx_data == csum) begin
              IM_offset     <= base_q;
              FLAG_IMoffset <= 1'b1;
              done          <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_im_program_loader.sv
// Testbench for im_program_loader: frames are modelled from byte-level rules
// (range check, word list, payload byte sum) and writes are collected by a monitor.
module tb_im_program_loader;

  localparam int TO = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] IM_offset;
  logic        FLAG_IMoffset;
  logic        hold_cpu;
  logic        done;
  logic        error;

  always #5 clock = ~clock;

  im_program_loader_if #(.DATA_WIDTH(32)) bus ();

  im_program_loader #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (14),
    .TIMEOUT_CYCLES(TO),
    .SYNC_BYTE     (8'hA5)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_wr        (bus),
    .IM_offset    (IM_offset),
    .FLAG_IMoffset(FLAG_IMoffset),
    .hold_cpu     (hold_cpu),
    .done         (done),
    .error        (error)
  );

  int          checks = 0;
  int          errors = 0;
  int          flag_cnt = 0;
  logic [63:0] seen_w[$];
  logic [31:0] exp_offset = '0;

  always @(negedge clock) begin
    if (bus.write === 1'b1) seen_w.push_back({bus.write_addr, bus.write_data});
    if (FLAG_IMoffset === 1'b1) flag_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      bus.rx_valid = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   guard;
    logic rdy;
    @(negedge clock);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    guard = 0;
    forever begin
      rdy = bus.rx_ready;
      @(posedge clock);
      if (rdy) break;
      guard++;
      if (guard > 8) begin
        checks++; errors++;
        $display("FAIL rx_ready_stuck got 0 want 1");
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 3; i >= 0; i--) begin
      if (gaps) idle($urandom_range(0, 2));
      send_byte(w[i*8 +: 8]);
    end
  endtask

  task automatic run_frame(input string name, input logic [31:0] base, input logic [31:0] len,
                           input logic [31:0] words[$], input logic [7:0] csum_xor, input bit gaps);
    logic [63:0] exp_w[$];
    logic [7:0]  sum;
    logic [31:0] w;
    bit          range_err, good;
    int          w0, f0;
    sum = '0;
    range_err = ({32'b0, base} + {32'b0, len}) > 64'd16384;
    if (!range_err) begin
      for (int i = 0; i < int'(len); i++) begin
        w = words[i];
        exp_w.push_back({base + 32'(i), w});
        sum = sum + w[31:24] + w[23:16] + w[15:8] + w[7:0];
      end
    end
    good = !range_err && (csum_xor == 8'h00);
    if (good) exp_offset = base;
    w0 = seen_w.size();
    f0 = flag_cnt;

    send_byte(8'hA5);
    #1;
    checks++;
    if (hold_cpu !== 1'b1) begin
      errors++; $display("FAIL %s hold_after_sync got %b want 1", name, hold_cpu);
    end
    send_word(base, gaps);
    send_word(len, gaps);
    if (!range_err) begin
      for (int i = 0; i < int'(len); i++) send_word(words[i], gaps);
      if (gaps) idle($urandom_range(0, 2));
      send_byte(sum ^ csum_xor);
    end
    idle(4);

    checks++;
    if (seen_w.size() - w0 !== exp_w.size()) begin
      errors++; $display("FAIL %s write_count got %0d want %0d", name, seen_w.size() - w0, exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && w0 + i < seen_w.size(); i++) begin
      checks++;
      if (seen_w[w0 + i] !== exp_w[i]) begin
        errors++; $display("FAIL %s write%0d got %h want %h", name, i, seen_w[w0 + i], exp_w[i]);
      end
    end
    checks++;
    if (flag_cnt - f0 !== int'(good)) begin
      errors++; $display("FAIL %s flag_pulses got %0d want %0d", name, flag_cnt - f0, int'(good));
    end
    checks++;
    if (IM_offset !== exp_offset) begin
      errors++; $display("FAIL %s IM_offset got %h want %h", name, IM_offset, exp_offset);
    end
    checks++;
    if (done !== good || error !== !good || hold_cpu !== 1'b0) begin
      errors++; $display("FAIL %s done_error_hold got %b%b%b want %b%b0", name, done, error, hold_cpu, good, !good);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (bus.rx_ready !== 1'b1 || bus.write !== 1'b0 || FLAG_IMoffset !== 1'b0 ||
        hold_cpu !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL %s ctrl got rdy%b wr%b flg%b hold%b done%b err%b want 1 0 0 0 0 0", name,
               bus.rx_ready, bus.write, FLAG_IMoffset, hold_cpu, done, error);
    end
    checks++;
    if (bus.write_addr !== 32'h0 || bus.write_data !== 32'h0 || IM_offset !== 32'h0) begin
      errors++;
      $display("FAIL %s regs got %h %h %h want 0 0 0", name, bus.write_addr, bus.write_data, IM_offset);
    end
  endtask

  task automatic test_reset();
    check_reset_values("reset");
  endtask

  task automatic test_good_frame();
    logic [31:0] wq[$];
    wq.push_back(32'hDEADBEEF);
    wq.push_back(32'h00000001);
    run_frame("good_frame", 32'h10, 32'd2, wq, 8'h00, 1'b0);
  endtask

  task automatic test_bad_checksum();
    logic [31:0] wq[$];
    wq.push_back(32'hDEADBEEF);
    wq.push_back(32'h00000001);
    run_frame("bad_csum", 32'h10, 32'd2, wq, 8'h0C, 1'b0);
  endtask

  task automatic test_range();
    logic [31:0] wq[$];
    wq.push_back(32'h11111111);
    wq.push_back(32'h22222222);
    run_frame("range_over", 32'h3FFF, 32'd2, wq, 8'h00, 1'b0);
    run_frame("range_edge", 32'h3FFE, 32'd2, wq, 8'h00, 1'b0);
    run_frame("range_huge", 32'hFFFF_FFFF, 32'hFFFF_FFFF, wq, 8'h00, 1'b0);
  endtask

  task automatic test_len_zero();
    logic [31:0] wq[$];
    run_frame("len_zero", 32'h0123, 32'd0, wq, 8'h00, 1'b0);
    run_frame("len_zero_top", 32'h4000, 32'd0, wq, 8'h00, 1'b0);
  endtask

  task automatic test_random_frames();
    logic [31:0] wq[$];
    logic [31:0] base, len;
    logic [7:0]  x;
    for (int n = 0; n < 16; n++) begin
      wq.delete();
      base = 32'($urandom_range(0, 16383));
      len  = 32'($urandom_range(0, 5));
      for (int i = 0; i < int'(len); i++) wq.push_back($urandom);
      x = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame("random", base, len, wq, x, 1'b1);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] wq[$];
    int w0;
    w0 = seen_w.size();
    send_byte(8'hA5);
    send_word(32'h20, 1'b0);
    send_word(32'd2, 1'b0);
    send_word(32'hCAFEF00D, 1'b0);
    send_byte(8'h12);
    send_byte(8'h34);
    idle(TO / 2);
    checks++;
    if (error !== 1'b0 || hold_cpu !== 1'b1) begin
      errors++; $display("FAIL timeout_early got err%b hold%b want err0 hold1", error, hold_cpu);
    end
    idle(TO);
    checks++;
    if (error !== 1'b1 || hold_cpu !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL timeout_abort got err%b hold%b done%b want err1 hold0 done0", error, hold_cpu, done);
    end
    checks++;
    if (seen_w.size() - w0 !== 1) begin
      errors++; $display("FAIL timeout_writes got %0d want 1", seen_w.size() - w0);
    end
    wq.push_back(32'h0BADC0DE);
    run_frame("after_timeout", 32'h40, 32'd1, wq, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] wq[$];
    logic [7:0]  b;
    int w0;
    send_byte(8'hA5);
    send_word(32'h100, 1'b0);
    send_word(32'd3, 1'b0);
    send_word(32'h01020304, 1'b0);
    send_byte(8'h55);
    @(negedge clock);
    reset = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h5A;
    @(negedge clock);
    check_reset_values("reset_mid");
    exp_offset = '0;
    reset = 1'b1;
    w0 = seen_w.size();
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h00;
      bus.rx_data = b;
      @(negedge clock);
    end
    bus.rx_valid = 1'b0;
    checks++;
    if (hold_cpu !== 1'b0 || seen_w.size() != w0 || done !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL garbage_ignored got hold%b writes%0d done%b err%b want 0 0 0 0",
                         hold_cpu, seen_w.size() - w0, done, error);
    end
    wq.push_back(32'hA5A5A5A5);
    wq.push_back(32'h5A5A5A5A);
    run_frame("after_reset", 32'h200, 32'd2, wq, 8'h00, 1'b0);
  endtask

  initial begin
    reset        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1'b1;
    idle(2);
    test_good_frame();
    test_bad_checksum();
    test_range();
    test_len_zero();
    test_random_frames();
    test_timeout();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
